// File: rtl/cpu_pkg.sv
// Shared register-file defaults, address/data types and sequencer states for the multicycle core.
package cpu_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_DEPTH  = 32;
  localparam int unsigned DEFAULT_ADDR_W = $clog2(DEFAULT_DEPTH);
  localparam int unsigned ZERO_ADDR      = 0;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEFAULT_DATA_W-1:0] word_t;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits tracking in-flight writes, plus RAW hazard flags for both read ports.
module rf_scoreboard
  import cpu_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_reserve_en,
  input  logic [ADDR_W-1:0] i_reserve_addr,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [ADDR_W-1:0] i_rs_addr,
  input  logic [ADDR_W-1:0] i_rt_addr,
  output logic              o_hazard_a,
  output logic              o_hazard_b
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_d;

  // Reserve applied after clear so a freshly issued producer wins a same-edge collision.
  always_comb begin
    w_busy_d = r_busy;
    if (i_en) begin
      if (i_wr_en) begin
        w_busy_d[i_wr_addr] = 1'b0;
      end
      if (i_reserve_en) begin
        w_busy_d[i_reserve_addr] = 1'b1;
      end
    end
    if (ZERO_REG != 0) begin
      w_busy_d[ADDR_W'(ZERO_ADDR)] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_d;
    end
  end

  always_comb begin
    o_hazard_a = i_en & r_busy[i_rs_addr] & ~(i_wr_en & (i_wr_addr == i_rs_addr));
    o_hazard_b = i_en & r_busy[i_rt_addr] & ~(i_wr_en & (i_wr_addr == i_rt_addr));
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with latched operands, write-through bypass,
// busy scoreboard and a post-reset sequencer that zeroes one entry per cycle.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] out_data_a,
  output logic [DATA_W-1:0] out_data_b,
  output logic              rd_valid,
  output logic              hazard_a,
  output logic              hazard_b,
  input  logic              reserve_en,
  input  logic [ADDR_W-1:0] reserve_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  rf_state_e         r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              r_ready;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_out_a;
  logic [DATA_W-1:0] r_out_b;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;
  logic [DATA_W-1:0] w_val_a;
  logic [DATA_W-1:0] w_val_b;

  function automatic logic [DATA_W-1:0] f_value(
    input logic [ADDR_W-1:0] x,
    input logic [DATA_W-1:0] mem_x,
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd
  );
    logic [DATA_W-1:0] v;
    if ((ZERO_REG != 0) && (x == ADDR_W'(ZERO_ADDR))) begin
      v = '0;
    end else if (we && (wa == x)) begin
      v = wd;
    end else begin
      v = mem_x;
    end
    return v;
  endfunction

  // One shared write port so the array maps onto a single-write RAM.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = wr_addr;
    w_mem_data = wr_data;
    if (rst) begin
      w_mem_we = 1'b0;
    end else if (r_state == RF_CLEAR) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_clr_ptr;
      w_mem_data = '0;
    end else if (wr_en && !((ZERO_REG != 0) && (wr_addr == ADDR_W'(ZERO_ADDR)))) begin
      w_mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  always_comb begin
    w_val_a = f_value(rs_addr, r_mem[rs_addr], wr_en, wr_addr, wr_data);
    w_val_b = f_value(rt_addr, r_mem[rt_addr], wr_en, wr_addr, wr_data);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RF_CLEAR;
      r_clr_ptr  <= '0;
      r_ready    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_out_a    <= '0;
      r_out_b    <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      if (r_state == RF_CLEAR) begin
        r_clr_ptr <= r_clr_ptr + 1'b1;
        if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
          r_state <= RF_RUN;
          r_ready <= 1'b1;
        end
      end else if (rd_en) begin
        r_out_a    <= w_val_a;
        r_out_b    <= w_val_b;
        r_rd_valid <= 1'b1;
      end
    end
  end

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .i_en           (r_ready),
    .i_reserve_en   (reserve_en),
    .i_reserve_addr (reserve_addr),
    .i_wr_en        (wr_en),
    .i_wr_addr      (wr_addr),
    .i_rs_addr      (rs_addr),
    .i_rt_addr      (rt_addr),
    .o_hazard_a     (hazard_a),
    .o_hazard_b     (hazard_b)
  );

  assign ready      = r_ready;
  assign rd_valid   = r_rd_valid;
  assign out_data_a = r_out_a;
  assign out_data_b = r_out_b;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, randomized traffic against a
// behavioural model, mid-clear reset restart, and a small no-zero-register configuration.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default configuration: 32 x 32, r0 hardwired.
  logic        c1_ready, c1_rd_en, c1_rd_valid, c1_hz_a, c1_hz_b, c1_res_en, c1_wr_en;
  logic [4:0]  c1_rs, c1_rt, c1_ra, c1_wa;
  logic [31:0] c1_a, c1_b, c1_wd;

  // Small configuration: 8 x 16, r0 ordinary.
  logic        c2_ready, c2_rd_en, c2_rd_valid, c2_hz_a, c2_hz_b, c2_res_en, c2_wr_en;
  logic [2:0]  c2_rs, c2_rt, c2_ra, c2_wa;
  logic [15:0] c2_a, c2_b, c2_wd;

  regfile_scoreboard u_dut1 (
    .clk(clk), .rst(rst), .ready(c1_ready), .rd_en(c1_rd_en), .rs_addr(c1_rs), .rt_addr(c1_rt),
    .out_data_a(c1_a), .out_data_b(c1_b), .rd_valid(c1_rd_valid), .hazard_a(c1_hz_a),
    .hazard_b(c1_hz_b), .reserve_en(c1_res_en), .reserve_addr(c1_ra), .wr_en(c1_wr_en),
    .wr_addr(c1_wa), .wr_data(c1_wd)
  );

  regfile_scoreboard #(.DATA_W(16), .DEPTH(8), .ZERO_REG(0)) u_dut2 (
    .clk(clk), .rst(rst), .ready(c2_ready), .rd_en(c2_rd_en), .rs_addr(c2_rs), .rt_addr(c2_rt),
    .out_data_a(c2_a), .out_data_b(c2_b), .rd_valid(c2_rd_valid), .hazard_a(c2_hz_a),
    .hazard_b(c2_hz_b), .reserve_en(c2_res_en), .reserve_addr(c2_ra), .wr_en(c2_wr_en),
    .wr_addr(c2_wa), .wr_data(c2_wd)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: architectural register contents, pending-producer set, operand latches.
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  logic [31:0] m_a, m_b;
  bit          m_rv;

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_a  = '0;
    m_b  = '0;
    m_rv = 1'b0;
  endtask

  function automatic logic [31:0] m_value(input int x);
    if (x == 0) return 32'h0;
    if (c1_wr_en && (int'(c1_wa) == x)) return c1_wd;
    return m_mem[x];
  endfunction

  function automatic bit m_hazard(input int x);
    return (x != 0) && m_busy[x] && !(c1_wr_en && (int'(c1_wa) == x));
  endfunction

  task automatic m_step();
    if (c1_rd_en) begin
      m_a  = m_value(int'(c1_rs));
      m_b  = m_value(int'(c1_rt));
      m_rv = 1'b1;
    end else begin
      m_rv = 1'b0;
    end
    if (c1_wr_en && c1_wa != 0) m_mem[c1_wa] = c1_wd;
    if (c1_wr_en) m_busy[c1_wa] = 1'b0;
    if (c1_res_en && c1_ra != 0) m_busy[c1_ra] = 1'b1;
  endtask

  task automatic c1_drive(input bit rd, input int rs, input int rt, input bit res, input int ra,
                          input bit wr, input int wa, input logic [31:0] wd);
    @(negedge clk);
    c1_rd_en  = rd;
    c1_rs     = 5'(rs);
    c1_rt     = 5'(rt);
    c1_res_en = res;
    c1_ra     = 5'(ra);
    c1_wr_en  = wr;
    c1_wa     = 5'(wa);
    c1_wd     = wd;
  endtask

  task automatic c1_cycle(input bit rd, input int rs, input int rt, input bit res, input int ra,
                          input bit wr, input int wa, input logic [31:0] wd, input string tag);
    c1_drive(rd, rs, rt, res, ra, wr, wa, wd);
    #1;
    chk({tag, " hazard_a"}, {31'd0, c1_hz_a}, {31'd0, m_hazard(rs)});
    chk({tag, " hazard_b"}, {31'd0, c1_hz_b}, {31'd0, m_hazard(rt)});
    m_step();
    @(posedge clk);
    #1;
    chk({tag, " rd_valid"}, {31'd0, c1_rd_valid}, {31'd0, m_rv});
    chk({tag, " out_a"}, c1_a, m_a);
    chk({tag, " out_b"}, c1_b, m_b);
  endtask

  // Counts edges after the last reset edge; ready must rise on exactly the DEPTH-th.
  task automatic ready_count(input string tag);
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s c1 ready@%0d", tag, k), {31'd0, c1_ready}, {31'd0, k == 32});
      chk($sformatf("%s c1 rd_valid@%0d", tag, k), {31'd0, c1_rd_valid}, 32'd0);
      if (k < 32) chk($sformatf("%s c1 hazard_a@%0d", tag, k), {31'd0, c1_hz_a}, 32'd0);
      chk($sformatf("%s c2 ready@%0d", tag, k), {31'd0, c2_ready}, {31'd0, k >= 8});
    end
  endtask

  typedef struct {
    bit rd; int rs; int rt; bit res; int ra; bit wr; int wa; logic [31:0] wd;
    bit hz_a; bit hz_b; bit rv; logic [31:0] a; logic [31:0] b;
  } vec_t;

  vec_t vt [14];

  function automatic int rnd_addr();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //      rd rs rt res ra wr wa wd            hz_a hz_b rv a             b
    vt[0]  = '{0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 32'h0,        32'h0};
    vt[1]  = '{1, 5, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 1, 32'hDEADBEEF, 32'h0};
    vt[2]  = '{0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'hDEADBEEF, 32'h0};
    vt[3]  = '{1, 0, 5, 0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        32'hDEADBEEF};
    vt[4]  = '{1, 7, 7, 0, 0, 1, 7, 32'h1234,     0, 0, 1, 32'h1234,     32'h1234};
    vt[5]  = '{1, 7, 5, 0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h1234,     32'hDEADBEEF};
    vt[6]  = '{0, 9, 9, 1, 9, 0, 0, 32'h0,        0, 0, 0, 32'h1234,     32'hDEADBEEF};
    vt[7]  = '{0, 9, 9, 0, 0, 0, 0, 32'h0,        1, 1, 0, 32'h1234,     32'hDEADBEEF};
    vt[8]  = '{1, 9, 9, 0, 0, 1, 9, 32'h99,       0, 0, 1, 32'h99,       32'h99};
    vt[9]  = '{0, 9, 9, 0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h99,       32'h99};
    vt[10] = '{0, 9, 0, 1, 9, 1, 9, 32'hAA,       0, 0, 0, 32'h99,       32'h99};
    vt[11] = '{1, 9, 0, 0, 0, 0, 0, 32'h0,        1, 0, 1, 32'hAA,       32'h0};
    vt[12] = '{0, 0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 32'hAA,       32'h0};
    vt[13] = '{0, 0, 9, 0, 0, 0, 0, 32'h0,        0, 1, 0, 32'hAA,       32'h0};

    // Requests held active through the clear sequence must all be ignored.
    c1_rd_en = 1'b1; c1_rs = 5'd9; c1_rt = 5'd9; c1_res_en = 1'b1; c1_ra = 5'd9;
    c1_wr_en = 1'b1; c1_wa = 5'd5; c1_wd = 32'hFFFFFFFF;
    c2_rd_en = 1'b0; c2_rs = '0; c2_rt = '0; c2_res_en = 1'b0; c2_ra = '0;
    c2_wr_en = 1'b0; c2_wa = '0; c2_wd = '0;
    m_reset();

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", {31'd0, c1_ready}, 32'd0);
    chk("reset rd_valid", {31'd0, c1_rd_valid}, 32'd0);
    chk("reset out_a", c1_a, 32'h0);
    chk("reset out_b", c1_b, 32'h0);
    chk("reset c2 ready", {31'd0, c2_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ready_count("init");

    for (int i = 0; i < 32; i++) c1_cycle(1, i, (i + 1) % 32, 0, 0, 0, 0, 0, "readall");

    for (int i = 0; i < 14; i++) begin
      c1_drive(vt[i].rd, vt[i].rs, vt[i].rt, vt[i].res, vt[i].ra, vt[i].wr, vt[i].wa, vt[i].wd);
      #1;
      chk($sformatf("vec%0d hazard_a", i), {31'd0, c1_hz_a}, {31'd0, vt[i].hz_a});
      chk($sformatf("vec%0d hazard_b", i), {31'd0, c1_hz_b}, {31'd0, vt[i].hz_b});
      m_step();
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d rd_valid", i), {31'd0, c1_rd_valid}, {31'd0, vt[i].rv});
      chk($sformatf("vec%0d out_a", i), c1_a, vt[i].a);
      chk($sformatf("vec%0d out_b", i), c1_b, vt[i].b);
    end

    for (int n = 0; n < 400; n++) begin
      c1_cycle(1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(), 1'($urandom_range(0, 2) == 0),
               rnd_addr(), 1'($urandom_range(0, 1)), rnd_addr(), $urandom(), "rand");
    end

    // Reset while run-state busy bits exist, then again once clr_ptr has reached 10.
    c1_cycle(0, 0, 0, 1, 3, 0, 0, 0, "pre-rst res3");
    c1_cycle(0, 3, 4, 1, 4, 0, 0, 0, "pre-rst res4");
    c1_drive(1, 3, 4, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrun rst ready", {31'd0, c1_ready}, 32'd0);
    chk("midrun rst out_a", c1_a, 32'h0);
    chk("midrun rst out_b", c1_b, 32'h0);
    chk("midrun rst rd_valid", {31'd0, c1_rd_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ready_count("restart");
    m_reset();
    c1_drive(0, 3, 4, 0, 0, 0, 0, 0);
    #1;
    chk("post-rst hazard_a r3", {31'd0, c1_hz_a}, 32'd0);
    chk("post-rst hazard_b r4", {31'd0, c1_hz_b}, 32'd0);
    for (int i = 0; i < 32; i++) c1_cycle(1, i, 31 - i, 0, 0, 0, 0, 0, "post-rst readall");

    // Small configuration: r0 is an ordinary register.
    @(negedge clk);
    c2_wr_en = 1'b1; c2_wa = 3'd0; c2_wd = 16'hBEEF;
    @(negedge clk);
    c2_wr_en = 1'b0; c2_rd_en = 1'b1; c2_rs = 3'd0; c2_rt = 3'd0;
    @(posedge clk);
    #1;
    chk("c2 r0 out_a", {16'd0, c2_a}, 32'hBEEF);
    chk("c2 r0 out_b", {16'd0, c2_b}, 32'hBEEF);
    chk("c2 rd_valid", {31'd0, c2_rd_valid}, 32'd1);
    @(negedge clk);
    c2_rd_en = 1'b0; c2_res_en = 1'b1; c2_ra = 3'd0;
    #1;
    chk("c2 hazard before reserve", {31'd0, c2_hz_a}, 32'd0);
    @(negedge clk);
    c2_res_en = 1'b0;
    #1;
    chk("c2 r0 hazard_a", {31'd0, c2_hz_a}, 32'd1);
    chk("c2 r0 hazard_b", {31'd0, c2_hz_b}, 32'd1);
    chk("c2 rd_valid drop", {31'd0, c2_rd_valid}, 32'd0);
    @(negedge clk);
    c2_wr_en = 1'b1; c2_wa = 3'd0; c2_wd = 16'h1234;
    #1;
    chk("c2 r0 hazard bypassed", {31'd0, c2_hz_a}, 32'd0);
    @(negedge clk);
    c2_wr_en = 1'b0; c2_rd_en = 1'b1;
    #1;
    chk("c2 r0 busy cleared", {31'd0, c2_hz_a}, 32'd0);
    @(posedge clk);
    #1;
    chk("c2 r0 reread", {16'd0, c2_a}, 32'h1234);
    @(negedge clk);
    c2_rd_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
